// File: rtl/prog_fetch_pkg.sv
// prog_fetch_pkg: FSM states, default sizes and the FIFO entry type for prog_fetch_master
package prog_fetch_pkg;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_WAIT, S_FIN} state_t;
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/prog_fetch_fifo.sv
// prog_fetch_fifo: synchronous FIFO, head entry presented from storage, full/empty by pointer MSB compare
module prog_fetch_fifo
  import prog_fetch_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  fifo_entry_t              din,
  input  logic                     pop,
  output fifo_entry_t              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  fifo_entry_t mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = empty ? '0 : mem[rptr[AW-1:0]];
  // read/write pointers; simultaneous push and pop both advance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end
  // entry storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/prog_fetch_master.sv
// prog_fetch_master: reads a block of words over a valid/ready bus and streams them out
// Optional bus timeout enabled by defining PROGFETCH_TIMEOUT_EN.
module prog_fetch_master
  import prog_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("prog_fetch_master: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end
  state_t state, state_n;
  logic [15:0] rem;
  logic [CW-1:0] fcount;
  logic full, empty, push, pop, fin_clear, timeout, unused_bits;
  fifo_entry_t push_entry, head;
  assign unused_bits = ^base_addr[1:0];
  assign push_entry = '{last: rem == 16'd1, data: mem_rdata};
  assign out_data = head.data;
  assign out_last = head.last;
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  // FIN may leave as soon as the final buffered word is being handed off
  assign fin_clear = empty || (fcount == CW'(1) && pop);
  prog_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fcount)
  );
`ifdef PROGFETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  // a ready arriving on the last allowed cycle still wins over the timeout
  assign timeout = state == S_REQ && !mem_ready && tcnt == TW'(TIMEOUT_CYCLES - 1);
  // cycles spent in the current REQ visit; GAP always separates visits so leaving REQ restarts it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tcnt <= '0;
    else tcnt <= state == S_REQ ? tcnt + 1'b1 : '0;
  end
  // sticky error, cleared by the next accepted start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) error <= 1'b0;
    else if (state == S_IDLE && start) error <= 1'b0;
    else if (timeout) error <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign error = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else state <= state_n;
  end
  // next-state logic; REQ is only entered with a guaranteed free FIFO slot
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = word_count == 16'd0 ? S_FIN : (full ? S_WAIT : S_REQ);
      S_REQ:  state_n = mem_ready ? S_GAP : (timeout ? S_FIN : S_REQ);
      S_GAP:  state_n = rem == 16'd0 ? S_FIN : (full ? S_WAIT : S_REQ);
      S_WAIT: state_n = full ? S_WAIT : S_REQ;
      S_FIN:  state_n = fin_clear ? S_IDLE : S_FIN;
      default: state_n = S_IDLE;
    endcase
  end
  // state-decoded outputs; ready outside REQ is never looked at
  always_comb begin
    mem_valid = state == S_REQ;
    push = mem_valid && mem_ready;
    busy = state != S_IDLE;
  end
  // address, remaining count and the registered done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_addr <= '0;
      rem <= '0;
      done <= 1'b0;
    end else begin
      done <= state == S_FIN && fin_clear;
      if (state == S_IDLE && start) begin
        mem_addr <= {base_addr[31:2], 2'b00};
        rem <= word_count;
      end else if (push) begin
        mem_addr <= mem_addr + 32'd4;
        rem <= rem - 16'd1;
      end else if (timeout) begin
        rem <= '0;
      end
    end
  end
endmodule

// File: tb/tb_prog_fetch_master.sv
// tb_prog_fetch_master: table vectors, hand sequences and random blocks against a stream model
module tb_prog_fetch_master;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [31:0] base_addr = '0, mem_rdata;
  logic [15:0] word_count = '0;
  logic busy, done, error, mem_valid, mem_ready, out_valid, out_last;
  logic [31:0] mem_addr, out_data;
  int vectors = 0, miscompares = 0, done_cnt = 0, stall_after = -1, ready_pct = 100;
  bit stale_en = 1'b0, hold_pending = 1'b0;
  logic [32:0] hold_val;
  logic [32:0] got_q[$];
  logic [31:0] addr_q[$];

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [15:0] cnt;
    int          pct;
    bit          stale;
    int          exp_reads;
    logic [31:0] exp_first;
    logic [31:0] exp_final;
  } vec_t;
  vec_t tbl[6];

  prog_fetch_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .error(error), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00100000: return 32'h020007b7;
      32'h00100004: return 32'h20010737;
      32'h00100008: return 32'h10678793;
      32'h0010000C: return 32'h00f72023;
      default:      return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h13579BDF;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // registered responder: ready one cycle after a request, optionally one stale extra cycle
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= (mem_valid && !mem_ready && !(stall_after >= 0 && addr_q.size() >= stall_after))
                   || (stale_en && mem_valid && mem_ready);
      mem_rdata <= (mem_valid && !mem_ready) ? rom(mem_addr) : 32'hDEADBEEF;
    end
  end

  // monitor on the falling edge: transfers, bus reads, done pulses, held-output stability
  always @(negedge clk) begin
    if (!rstn) begin
      hold_pending <= 1'b0;
    end else begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (mem_valid && mem_ready) addr_q.push_back(mem_addr);
      if (done) done_cnt++;
      if (hold_pending) check("hold stable", {out_valid, out_last, out_data}, {1'b1, hold_val});
      hold_pending <= out_valid && !out_ready;
      hold_val <= {out_last, out_data};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    out_ready = int'($urandom_range(99)) < ready_pct;
  endtask

  task automatic clear_obs();
    got_q.delete();
    addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    int cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      step();
      cyc++;
    end
    check("done count", done_cnt, 1);
    check("busy after done", busy, 0);
  endtask

  task automatic run_block(input logic [31:0] base, input logic [15:0] cnt, input int budget);
    clear_obs();
    base_addr = base;
    word_count = cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(budget);
  endtask

  task automatic compare_stream(input logic [31:0] base, input int n, input bit last_final, input string tag);
    logic [31:0] a;
    check({tag, " words"}, got_q.size(), n);
    check({tag, " reads"}, addr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      a = {base[31:2], 2'b00} + 32'(4 * i);
      if (i < got_q.size()) check($sformatf("%s data[%0d]", tag, i), got_q[i], {last_final && (i == n - 1), rom(a)});
      if (i < addr_q.size()) check($sformatf("%s addr[%0d]", tag, i), addr_q[i], a);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ctl"}, {busy, done, error, mem_valid, out_valid, out_last}, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " out_data"}, out_data, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"basic", 32'h00100000, 16'd4, 100, 1'b0, 4, 32'h00100000, 32'h0010000C};
    tbl[1] = '{"wrap", 32'hFFFFFFFE, 16'd2, 100, 1'b0, 2, 32'hFFFFFFFC, 32'h00000000};
    tbl[2] = '{"stale", 32'h00002003, 16'd5, 100, 1'b1, 5, 32'h00002000, 32'h00002010};
    tbl[3] = '{"single", 32'h00000040, 16'd1, 50, 1'b0, 1, 32'h00000040, 32'h00000040};
    tbl[4] = '{"zero", 32'h00100000, 16'd0, 100, 1'b0, 0, 32'h0, 32'h0};
    tbl[5] = '{"slow_stale", 32'h0000FFF0, 16'd7, 30, 1'b1, 7, 32'h0000FFF0, 32'h00010008};
    #12;
    check_reset("reset");
    rstn = 1'b1;
    step();

    // start to first request is one cycle
    clear_obs();
    base_addr = 32'h00000500;
    word_count = 16'd1;
    start = 1'b1;
    @(negedge clk);
    check("lat valid before", mem_valid, 0);
    step();
    start = 1'b0;
    @(negedge clk);
    check("lat valid after", {mem_valid, busy}, 2'b11);
    check("lat addr", mem_addr, 32'h00000500);
    wait_done(100);
    compare_stream(32'h00000500, 1, 1'b1, "lat");

    // zero count: done two cycles after start, no bus activity
    clear_obs();
    base_addr = 32'h00001234;
    word_count = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("zc c1", {done, busy}, 2'b01);
    step();
    @(negedge clk);
    check("zc c2", {done, busy}, 2'b10);
    step();
    check("zc done count", done_cnt, 1);
    check("zc reads", addr_q.size(), 0);

    foreach (tbl[k]) begin
      ready_pct = tbl[k].pct;
      stale_en = tbl[k].stale;
      run_block(tbl[k].base, tbl[k].cnt, 400);
      compare_stream(tbl[k].base, int'(tbl[k].cnt), 1'b1, tbl[k].name);
      check({tbl[k].name, " nreads"}, addr_q.size(), tbl[k].exp_reads);
      if (addr_q.size() > 0) begin
        check({tbl[k].name, " first"}, addr_q[0], tbl[k].exp_first);
        check({tbl[k].name, " final"}, addr_q[addr_q.size() - 1], tbl[k].exp_final);
      end
      check({tbl[k].name, " error"}, error, 0);
    end
    stale_en = 1'b0;

    // backpressure: four reads fill the buffer, a start while busy is ignored
    ready_pct = 0;
    clear_obs();
    base_addr = 32'h00001000;
    word_count = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    base_addr = 32'h00009000;
    word_count = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (29) step();
    @(negedge clk);
    check("bp reads", addr_q.size(), 4);
    check("bp idle bus", {mem_valid, out_valid, busy}, 3'b011);
    ready_pct = 100;
    wait_done(300);
    compare_stream(32'h00001000, 10, 1'b1, "bp");

    // reset during the fifth request of eight
    begin
      int cyc = 0;
      clear_obs();
      base_addr = 32'h00002000;
      word_count = 16'd8;
      start = 1'b1;
      step();
      start = 1'b0;
      while (addr_q.size() < 4 && cyc < 200) begin step(); cyc++; end
      while (!mem_valid && cyc < 200) begin step(); cyc++; end
      check("mid reach word5", cyc < 200, 1);
    end
    #2 rstn = 1'b0;
    #1 check_reset("mid reset");
    @(posedge clk);
    #1 check_reset("mid held");
    rstn = 1'b1;
    step();
    run_block(32'h00003000, 16'd2, 100);
    compare_stream(32'h00003000, 2, 1'b1, "after reset");

`ifdef PROGFETCH_TIMEOUT_EN
    // responder goes silent after two words of six
    stall_after = 2;
    run_block(32'h00004000, 16'd6, 300);
    stall_after = -1;
    compare_stream(32'h00004000, 2, 1'b0, "timeout");
    check("timeout error", error, 1);
    run_block(32'h00004100, 16'd1, 100);
    compare_stream(32'h00004100, 1, 1'b1, "post timeout");
    check("error cleared", error, 0);
`endif

    // random blocks against the stream model
    for (int r = 0; r < 25; r++) begin
      logic [31:0] b;
      logic [15:0] n;
      b = $urandom;
      n = 16'($urandom_range(9));
      ready_pct = int'($urandom_range(100, 20));
      stale_en = 1'($urandom_range(1));
      run_block(b, n, 100 + 40 * int'(n));
      compare_stream(b, int'(n), 1'b1, $sformatf("rnd%0d", r));
      check($sformatf("rnd%0d error", r), error, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prog_fetch_master.md
# prog_fetch_master

Bus initiator for the PicoRV32-style `valid`/`ready`/`addr`/`rdata` memory interface, i.e. the requesting end of the program-memory port.
- On a start pulse it reads a contiguous block of 32-bit words from a memory responder such as the program ROM.
- The words are buffered in a small FIFO and delivered on a valid/ready output stream, with the final word tagged `out_last`.
- Its uses are boot-time copy, memory checks and firmware image streaming.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: output buffer depth in words. Must be a power of 2 and at least 2.
- `TIMEOUT_CYCLES`, 255: bus timeout limit in cycles. Used only when `PROGFETCH_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: the single clock.
- `rstn` in 1: reset, asynchronous assert, active low.
- `start` in 1: one-cycle start pulse.
- `base_addr` in 32: byte address of the first word. Bits [1:0] are ignored.
- `word_count` in 16: number of words to read.
- `busy` out 1: high from the accepted start until `done`.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: sticky timeout flag.
- `mem_valid` out 1: bus request.
- `mem_ready` in 1: bus response strobe.
- `mem_addr` out 32: word-aligned request address.
- `mem_rdata` in 32: read data, sampled in the `mem_ready` cycle.
- `out_valid` out 1: stream data valid.
- `out_ready` in 1: stream sink ready.
- `out_data` out 32: stream word.
- `out_last` out 1: marks the final word of a block.

## Operation
FSM states and transitions:
- **IDLE**
  - On `start`, latch `{base_addr[31:2],2'b00}` and `word_count`, clear `error`, raise `busy`.
  - If `word_count`==0, go to FIN.
  - Otherwise go to REQ if the FIFO has space, else WAIT.
- **REQ**
  - `mem_valid`=1 and `mem_addr` is held stable.
  - When `mem_ready` is high: push `mem_rdata` into the FIFO, add 4 to the address, decrement the remaining count, and go to GAP.
- **GAP**
  - Exactly one cycle with `mem_valid`=0. This is mandatory because the responder's registered ready can pulse once after valid drops.
  - If words remain: go to REQ if the FIFO has a free slot, else WAIT. If none remain, go to FIN.
- **WAIT**: hold until the FIFO is not full, then go to REQ.
- **FIN**
  - Wait until the FIFO is empty, then pulse `done`, drop `busy`, and return to IDLE.
  - `done` and the `busy` fall occur on the same edge.

Bus and stream rules:
- `mem_ready` is ignored whenever `mem_valid`=0.
- At most one request is outstanding. A request is issued only when a FIFO slot is guaranteed, so read data is never dropped.
- `out_last`=1 on the word whose push took the remaining count from 1 to 0. A `last` bit is stored per FIFO entry.
- Output transfer happens when `out_valid && out_ready`. `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- The address wraps modulo 2^32: 0xFFFFFFFC is followed by 0x00000000.
- `start` while `busy` is ignored. Inputs are latched only in IDLE.
- Reset mid-operation (`rstn` low) immediately clears the FSM, counters and FIFO. The in-flight bus request is abandoned.

Reset values: `busy`=0, `done`=0, `error`=0, `mem_valid`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0.

## Timing
- `start` to the first `mem_valid` high: 1 cycle (REQ is entered on the edge after `start`).
- Per word against a responder with 1-cycle registered ready: 3 cycles (REQ×2 + GAP). Steady-state throughput is 1 word per 3 cycles.
- FIFO push to `out_valid`: 1 cycle (registered FIFO output).
- Last output handshake to `done`: 1 cycle.
- A FIFO push and pop in the same cycle are both performed and the occupancy is unchanged.

## Configuration
`PROGFETCH_TIMEOUT_EN` defined:
- A counter runs while in REQ and resets on every REQ entry.
- On reaching `TIMEOUT_CYCLES` without `mem_ready`:
  - drop `mem_valid`, set `error`, and discard the remaining count;
  - go to FIN, so words already in the FIFO are still delivered;
  - `out_last` is never asserted for the aborted block.
- `mem_ready` arriving in the same cycle as the timeout wins: the word is accepted and there is no error.

`PROGFETCH_TIMEOUT_EN` not defined:
- REQ waits indefinitely.
- `error` is tied to 0 and no counter logic is present.

## Structure
Shared package `prog_fetch_pkg` holds:
- the FSM state enum (IDLE, REQ, GAP, WAIT, FIN);
- the default constants for `FIFO_DEPTH` and `TIMEOUT_CYCLES`;
- the 33-bit FIFO entry type `{last, data}`.

Sub-module `prog_fetch_fifo`:
- synchronous FIFO with registered output;
- `full`/`empty` flags using pointer MSB compare;
- instantiated once.

The FSM, address/count registers and timeout counter live in `prog_fetch_master`.

## Test plan
- **Basic read:** `base_addr`=0x00100000, `word_count`=4, `out_ready`=1, behavioural ROM holding 0x020007b7, 0x20010737, 0x10678793, 0x00f72023 -> those 4 words in order, `out_last` only on the 4th, one `done`, `mem_addr` steps 0x00100000..0x0010000C.
- **Backpressure:** `word_count`=10, FIFO_DEPTH=4, `out_ready`=0 for 40 cycles -> exactly 4 bus reads then `mem_valid` stays 0. After `out_ready`=1, all 10 words are delivered with none lost or duplicated.
- **Zero count and wrap:** `word_count`=0 -> `done` 2 cycles after `start`, no `mem_valid`. `base_addr`=0xFFFFFFFE, `word_count`=2 -> addresses 0xFFFFFFFC then 0x00000000.
- **Stale ready:** responder keeps ready high one cycle after valid drops -> no extra FIFO push; word count is exact.
- **Timeout (`PROGFETCH_TIMEOUT_EN`, TIMEOUT_CYCLES=8):** responder stops answering at word 3 of 6 -> 2 words are delivered, `error`=1, `done` pulses, `out_last` is never set. A new `start` clears `error`.
- **Reset mid-block:** `rstn` pulsed low during word 5 of 8 -> all outputs at reset values. A following `start` with `word_count`=2 completes normally.
